mp_link_tx: RTL and testbench
=============================

// Module: mp_link_tx
// PURPOSE
//  Multiplayer link transmitter: sends local game events (ready, hit, game over) plus a heartbeat
//  to the opponent board as framed UART-style bytes on one wire. It sits beside CORE on the pixel
//  clock. It consumes CORE's player_ready/player_hit/game_over/multiplayer. The opponent's link
//  receiver regenerates opponent_ready/opponent_hit/victory from these frames.
// PARAMETERS
//  CLKS_PER_BIT  564         clk cycles per serial bit (65 MHz / 115200 baud)
//  HB_PERIOD     6_500_000   clk cycles between heartbeat frames (100 ms)
// PORTS
//  clk            in   1   pixel clock; sole clock domain
//  rst            in   1   asynchronous, active-low reset
//  multiplayer    in   1   link enable; 0 = no new frames queued
//  player_ready   in   1   level: local player ready
//  player_hit     in   1   local damage; level may last >1 cycle, one hit per rising edge
//  game_over      in   1   level: local player lost
//  tx             out  1   serial line, idle high
//  busy           out  1   frame in flight (START..STOP)
//  frames_sent    out  16  count of completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset values (async, immediate, also mid-frame): tx=1, busy=0, frames_sent=0, all pending=0,
//   last_ready_sent=0, hit_cnt=0, hb_cnt=0, hb_seq=0, FSM=IDLE.
//  Frame (11 bits, each CLKS_PER_BIT cycles): start 0, data[0..7] LSB first, even parity
//   (^data), stop 1. Payload {type[2:0],arg[4:0]}:
//   READY 3'b001 arg={4'b0,ready}; HIT 3'b010 arg={2'b0,hit_cnt};
//   GAME_OVER 3'b011 arg=0; HEARTBEAT 3'b100 arg=hb_seq.
//  Event capture, only while multiplayer=1:
//   - hit: registered rising edge of player_hit -> hit_cnt+1, saturates at 7.
//   - ready: pending while player_ready != last_ready_sent; frame carries level at load time.
//   - game_over: rising edge sets go_pend, sticky until sent.
//   - heartbeat: hb_cnt counts to HB_PERIOD-1 then wraps and sets hb_pend.
//  Selection in IDLE, fixed priority GAME_OVER > HIT > READY > HEARTBEAT; one frame per IDLE
//   visit. Selected pending source is cleared in the same cycle:
//   hit_cnt<=0 (or 1 if a new edge arrives that cycle: edges never lost),
//   last_ready_sent<=player_ready, go_pend<=0, hb_pend<=0 and hb_seq+1 (5-bit wrap).
//  FSM: IDLE -> START (tx=0 on cycle after load) -> DATA (8 bits) -> PARITY -> STOP -> IDLE.
//   busy=1 from START through last STOP cycle. frames_sent+1 on STOP exit. Back-to-back pending
//   frames: next START begins 1 cycle after STOP ends (1 IDLE cycle).
//  Latency: event edge -> tx falling = 3 clk when IDLE (edge reg, pending, load).
//  multiplayer 1->0: all pending cleared, hit_cnt=0, hb_cnt held 0; frame in flight completes.
//   multiplayer 0->1: last_ready_sent forced 0, so ready=1 is sent on enable.
//  Events during busy accumulate; hits beyond 7 before sending are dropped (saturation).
//  Bit timer: down-counter CLKS_PER_BIT-1..0; width $clog2(CLKS_PER_BIT).
// STRUCTURE
//  mp_link_defs.vh (shared with mp_link_rx): type codes, FRAME_BITS=11, default CLKS_PER_BIT.
//  Sub-module mp_link_tx_shifter: bit timer + 11-bit shift register + busy/done. Parent holds
//   event capture, priority select, heartbeat, counters.
// TESTING (bench overrides CLKS_PER_BIT=16, HB_PERIOD=4000)
//  1 player_hit 1->0 pulse of 5 cycles, multiplayer=1 -> one frame data 0x41, parity 0;
//    frames_sent=1.
//  2 player_ready 0->1 -> data 0x21 parity 0; ready held 1 -> no further READY frames.
//  3 3 hit edges during a busy frame -> next frame 0x43 parity 1; 9 edges -> 0x47 (saturated).
//  4 game_over and hit edge same cycle -> 0x60 then 0x41, gap exactly 1 idle cycle.
//  5 idle 4000 cycles -> heartbeat 0x80 parity 1; next heartbeat 0x81.
//  6 rst low mid DATA -> tx=1, busy=0 same cycle. multiplayer=0 mid-frame -> frame completes,
//    pending dropped.

Source files
------------

// File: rtl/mp_link_pkg.sv
// Shared link definitions: frame type codes, frame geometry, defaults.
// Also used by the opponent-side receiver.
package mp_link_pkg;

    localparam int FRAME_BITS       = 11;
    localparam int DEF_CLKS_PER_BIT = 564;
    localparam int DEF_HB_PERIOD    = 6_500_000;

    typedef enum logic [2:0] {
        T_READY     = 3'b001,
        T_HIT       = 3'b010,
        T_GAME_OVER = 3'b011,
        T_HEARTBEAT = 3'b100
    } frame_type_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

    typedef struct packed {
        frame_type_e ftype;
        logic [4:0]  arg;
    } payload_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mp_link_tx_shifter.sv
// Serialiser: bit timer, start/data/parity/stop shifting, busy and done.
// One frame per load; load is only honoured in IDLE.
module mp_link_tx_shifter
    import mp_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       idle_o,
    output logic       done_o
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

    tx_state_e             state_q;
    logic [TW-1:0]         tmr_q;
    logic [2:0]            idx_q;
    logic [FRAME_BITS-2:0] sr_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  bit_end;

    assign bit_end = (tmr_q == '0);
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign idle_o  = (state_q == S_IDLE);
    assign done_o  = (state_q == S_STOP) && bit_end;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (load_i) begin
                state_q <= S_START;
                tmr_q   <= TMAX;
                sr_q    <= {1'b1, even_parity(data_i), data_i};
                tx_q    <= 1'b0;
                busy_q  <= 1'b1;
            end
        end else if (bit_end) begin
            // sr_q holds the bits still to go out, LSB next
            tmr_q <= TMAX;
            tx_q  <= sr_q[0];
            sr_q  <= {1'b1, sr_q[FRAME_BITS-2:1]};
            unique case (state_q)
                S_START: begin
                    state_q <= S_DATA;
                    idx_q   <= '0;
                end
                S_DATA: begin
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd7) state_q <= S_PARITY;
                end
                S_PARITY: state_q <= S_STOP;
                S_STOP: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end else begin
            tmr_q <= tmr_q - TW'(1);
        end
    end

endmodule

// File: rtl/mp_link_tx.sv
// Multiplayer link transmitter: captures game events and a heartbeat,
// picks one by priority and sends it as a parity-protected serial frame.
module mp_link_tx
    import mp_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int HB_PERIOD    = DEF_HB_PERIOD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        multiplayer,
    input  logic        player_ready,
    input  logic        player_hit,
    input  logic        game_over,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int HW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
    localparam logic [HW-1:0] HB_MAX = HW'(HB_PERIOD - 1);

    logic          hit_prev_q, hit_rise_q;
    logic          go_prev_q, go_rise_q;
    logic [2:0]    hit_cnt_q, hit_cnt_d;
    logic          go_pend_q, go_pend_d;
    logic          hb_pend_q, hb_pend_d;
    logic          last_rdy_q, last_rdy_d;
    logic [HW-1:0] hb_cnt_q, hb_cnt_d;
    logic [4:0]    hb_seq_q, hb_seq_d;
    logic [15:0]   fs_q, fs_d;

    logic     idle, done, load, rdy_pend;
    logic     sel_go, sel_hit, sel_rdy, sel_hb;
    payload_t pl;

    assign rdy_pend    = (player_ready != last_rdy_q);
    assign load        = sel_go | sel_hit | sel_rdy | sel_hb;
    assign frames_sent = fs_q;

    always_comb begin
        sel_go  = 1'b0;
        sel_hit = 1'b0;
        sel_rdy = 1'b0;
        sel_hb  = 1'b0;
        pl      = '{T_HEARTBEAT, hb_seq_q};
        if (multiplayer && idle) begin
            if (go_pend_q) begin
                sel_go = 1'b1;
                pl     = '{T_GAME_OVER, 5'd0};
            end else if (hit_cnt_q != 3'd0) begin
                sel_hit = 1'b1;
                pl      = '{T_HIT, {2'b00, hit_cnt_q}};
            end else if (rdy_pend) begin
                sel_rdy = 1'b1;
                pl      = '{T_READY, {4'b0000, player_ready}};
            end else if (hb_pend_q) begin
                sel_hb = 1'b1;
            end
        end
    end

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        go_pend_d  = go_pend_q;
        hb_pend_d  = hb_pend_q;
        last_rdy_d = last_rdy_q;
        hb_cnt_d   = hb_cnt_q;
        hb_seq_d   = hb_seq_q;
        fs_d       = fs_q + 16'(done);
        if (!multiplayer) begin
            hit_cnt_d  = '0;
            go_pend_d  = 1'b0;
            hb_pend_d  = 1'b0;
            last_rdy_d = 1'b0;
            hb_cnt_d   = '0;
        end else begin
            // clear first, then count, so an edge in the send cycle survives
            if (sel_hit) hit_cnt_d = '0;
            if (hit_rise_q && hit_cnt_d != 3'd7)
                hit_cnt_d = hit_cnt_d + 3'd1;
            if (sel_rdy) last_rdy_d = player_ready;
            if (sel_go) go_pend_d = 1'b0;
            if (go_rise_q) go_pend_d = 1'b1;
            if (sel_hb) begin
                hb_pend_d = 1'b0;
                hb_seq_d  = hb_seq_q + 5'd1;
            end
            if (hb_cnt_q == HB_MAX) begin
                hb_cnt_d  = '0;
                hb_pend_d = 1'b1;
            end else begin
                hb_cnt_d = hb_cnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_prev_q <= 1'b0;
            hit_rise_q <= 1'b0;
            go_prev_q  <= 1'b0;
            go_rise_q  <= 1'b0;
            hit_cnt_q  <= '0;
            go_pend_q  <= 1'b0;
            hb_pend_q  <= 1'b0;
            last_rdy_q <= 1'b0;
            hb_cnt_q   <= '0;
            hb_seq_q   <= '0;
            fs_q       <= '0;
        end else begin
            hit_prev_q <= player_hit;
            hit_rise_q <= player_hit & ~hit_prev_q;
            go_prev_q  <= game_over;
            go_rise_q  <= game_over & ~go_prev_q;
            hit_cnt_q  <= hit_cnt_d;
            go_pend_q  <= go_pend_d;
            hb_pend_q  <= hb_pend_d;
            last_rdy_q <= last_rdy_d;
            hb_cnt_q   <= hb_cnt_d;
            hb_seq_q   <= hb_seq_d;
            fs_q       <= fs_d;
        end
    end

    mp_link_tx_shifter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_shifter (
        .clk_i (clk),
        .rst_ni(rst),
        .load_i(load),
        .data_i(pl),
        .tx_o  (tx),
        .busy_o(busy),
        .idle_o(idle),
        .done_o(done)
    );

endmodule

// File: tb/tb_mp_link_tx.sv
// Directed bench for mp_link_tx: decodes frames off the tx line and
// compares payload, parity, framing, counters and timing.
module tb_mp_link_tx;

    localparam int CPB = 16;
    localparam int HBP = 4000;
    localparam int LIM = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        mp, rdy, hit, go;
    logic        tx, busy;
    logic [15:0] fs;

    int checks   = 0;
    int failures = 0;
    int exp_fs   = 0;

    always #5 clk = ~clk;

    mp_link_tx #(
        .CLKS_PER_BIT(CPB),
        .HB_PERIOD   (HBP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .multiplayer (mp),
        .player_ready(rdy),
        .player_hit  (hit),
        .game_over   (go),
        .tx          (tx),
        .busy        (busy),
        .frames_sent (fs)
    );

    typedef enum {EV_HIT, EV_READY, EV_GO} ev_e;
    typedef struct {
        ev_e        ev;
        logic [7:0] d;
        logic       p;
        int         lat;
    } vec_t;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input string nm, input logic [7:0] ed,
                             input logic ep, input int lim,
                             output int lat);
        logic [7:0] d;
        logic p, s0, s1;
        d = 'x; p = 'x; s0 = 'x; s1 = 'x;
        lat = 0;
        while (tx !== 1'b0 && lat < lim) begin
            tick();
            lat++;
        end
        chk({nm, "_start_seen"}, tx, 1'b0);
        if (tx === 1'b0) begin
            repeat (CPB / 2) tick();
            s0 = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) tick();
                d[i] = tx;
            end
            repeat (CPB) tick();
            p = tx;
            repeat (CPB) tick();
            s1 = tx;
        end
        chk({nm, "_startbit"}, s0, 1'b0);
        chk({nm, "_data"}, d, ed);
        chk({nm, "_parity"}, p, ep);
        chk({nm, "_stopbit"}, s1, 1'b1);
        exp_fs++;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy !== 1'b0 && n < LIM) begin
            tick();
            n++;
        end
        chk({nm, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_busy(input string nm);
        int n = 0;
        while (busy !== 1'b1 && n < LIM) begin
            tick();
            n++;
        end
        chk({nm, "_busy"}, busy, 1'b1);
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick();
    endtask

    task automatic quiet(input string nm, input int n);
        logic bad = 1'b0;
        repeat (n) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        chk({nm, "_line_quiet"}, bad, 1'b0);
        chk({nm, "_frames_sent"}, fs, exp_fs[15:0]);
    endtask

    task automatic cleanup(input string nm);
        wait_idle(nm);
        mp = 1'b0;
        repeat (3) tick();
        rdy = 1'b0;
        go  = 1'b0;
        hit = 1'b0;
        repeat (3) tick();
        mp = 1'b1;
        tick();
    endtask

    initial begin
        vec_t vt[3];
        int   lat;
        int   n;

        vt[0] = '{EV_HIT,   8'h41, 1'b0, 3};
        vt[1] = '{EV_READY, 8'h21, 1'b0, -1};
        vt[2] = '{EV_GO,    8'h60, 1'b0, 3};

        rst = 1'b0;
        mp  = 1'b0;
        rdy = 1'b0;
        hit = 1'b0;
        go  = 1'b0;
        repeat (3) tick();
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_frames", fs, 16'h0);
        rst = 1'b1;
        tick();
        mp = 1'b1;
        quiet("enable_no_event", 20);

        for (int i = 0; i < 3; i++) begin
            string nm = $sformatf("vec%0d", i);
            fork
                begin
                    case (vt[i].ev)
                        EV_HIT: begin
                            hit = 1'b1;
                            repeat (5) tick();
                            hit = 1'b0;
                        end
                        EV_READY: rdy = 1'b1;
                        default:  go  = 1'b1;
                    endcase
                end
                run_frame(nm, vt[i].d, vt[i].p, 20, lat);
            join
            if (vt[i].lat >= 0) chk({nm, "_latency"}, lat, vt[i].lat);
            wait_idle(nm);
            chk({nm, "_frames"}, fs, exp_fs[15:0]);
            quiet({nm, "_held"}, 250);
            cleanup(nm);
        end

        fork
            run_frame("acc_first", 8'h41, 1'b0, 20, lat);
            begin
                pulse_hit();
                wait_busy("acc");
                repeat (3) pulse_hit();
            end
        join
        run_frame("acc3", 8'h43, 1'b1, LIM, lat);
        wait_idle("acc3");
        repeat (2) tick();
        fork
            run_frame("sat_first", 8'h41, 1'b0, 20, lat);
            begin
                pulse_hit();
                wait_busy("sat");
                repeat (9) pulse_hit();
            end
        join
        run_frame("sat7", 8'h47, 1'b0, LIM, lat);
        wait_idle("sat7");
        chk("acc_frames", fs, exp_fs[15:0]);
        cleanup("acc");

        fork
            begin
                go  = 1'b1;
                hit = 1'b1;
                tick();
                hit = 1'b0;
            end
            run_frame("prio_go", 8'h60, 1'b0, 20, lat);
        join
        n = 0;
        while (busy === 1'b1 && n < LIM) begin
            tick();
            n++;
        end
        n = 0;
        while (busy === 1'b0 && n < 50) begin
            n++;
            tick();
        end
        chk("prio_gap_cycles", n, 1);
        run_frame("prio_hit", 8'h41, 1'b0, 20, lat);
        chk("prio_hit_lat", lat, 0);
        wait_idle("prio");
        chk("prio_frames", fs, exp_fs[15:0]);
        cleanup("prio");

        run_frame("hb0", 8'h80, 1'b1, HBP + 100, lat);
        chk("hb0_period", (lat >= HBP - 5 && lat <= HBP + 5), 1'b1);
        wait_idle("hb0");
        run_frame("hb1", 8'h81, 1'b0, HBP + 100, lat);
        wait_idle("hb1");
        chk("hb_frames", fs, exp_fs[15:0]);
        cleanup("hb");

        fork
            run_frame("mpdrop", 8'h41, 1'b0, 20, lat);
            begin
                pulse_hit();
                wait_busy("mpdrop");
                pulse_hit();
                pulse_hit();
                repeat (20) tick();
                mp = 1'b0;
            end
        join
        wait_idle("mpdrop");
        quiet("mpdrop_after", 300);
        mp = 1'b1;
        quiet("mpdrop_reenable", 100);

        hit = 1'b1;
        tick();
        hit = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        repeat (2 * CPB + CPB / 2) tick();
        chk("rst_pre_tx", tx, 1'b0);
        chk("rst_pre_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_frames", fs, 16'h0);
        exp_fs = 0;
        tick();
        rst = 1'b1;
        quiet("rst_after", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
